// File: rtl/pit_pkg.sv
// Shared encodings for the 8253-style interval timer channel.
package pit_pkg;

   localparam int COUNT_W = 16;

   localparam logic [1:0] MODE_0 = 2'd0;
   localparam logic [1:0] MODE_2 = 2'd2;
   localparam logic [1:0] MODE_3 = 2'd3;

   localparam logic [1:0] ACC_LATCH = 2'b00;
   localparam logic [1:0] ACC_LSB   = 2'b01;
   localparam logic [1:0] ACC_MSB   = 2'b10;
   localparam logic [1:0] ACC_WORD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      COUNT = 2'd2
   } pit_state_e;

   // Control-word M field to supported mode: 1/4/5 fold to 0, 6 to 2, 7 to 3.
   function automatic logic [1:0] map_mode(input logic [2:0] m);
      return m[1] ? m[1:0] : MODE_0;
   endfunction

endpackage

// File: rtl/pit_dec.sv
// Counter decrement by 1 or 2 with zero detect; BCD path built only with PIT_BCD_EN.
module pit_dec
   import pit_pkg::*;
(
   input  logic [COUNT_W-1:0] val_i,
   input  logic               by2_i,
`ifdef PIT_BCD_EN
   input  logic               bcd_i,
`endif
   output logic [COUNT_W-1:0] res_o,
   output logic               zero_o
);

   logic [COUNT_W-1:0] bin_res;

   assign bin_res = val_i - (by2_i ? 16'd2 : 16'd1);

`ifdef PIT_BCD_EN
   logic [COUNT_W-1:0] bcd_res;

   // Digit-serial subtract with borrow; 0000 wraps to 9999 (or 9998).
   always_comb begin
      logic [4:0] sub;
      logic [4:0] dig;
      bcd_res = '0;
      sub     = by2_i ? 5'd2 : 5'd1;
      dig     = '0;
      for (int i = 0; i < 4; i++) begin
         dig = {1'b0, val_i[4*i +: 4]};
         if (dig < sub) begin
            bcd_res[4*i +: 4] = 4'(dig + 5'd10 - sub);
            sub = 5'd1;
         end else begin
            bcd_res[4*i +: 4] = 4'(dig - sub);
            sub = 5'd0;
         end
      end
   end

   assign res_o = bcd_i ? bcd_res : bin_res;
`else
   assign res_o = bin_res;
`endif

   assign zero_o = (res_o == '0);

endmodule

// File: rtl/pit_channel.sv
// One 8253-style PIT channel (modes 0/2/3) fed by an upstream clock enable.
// Optional BCD counting is built when PIT_BCD_EN is defined.
module pit_channel
   import pit_pkg::*;
#(
   parameter int DIV = 3
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iClkEn,
   input  logic       iGate,
   input  logic       iCtrlWr,
   input  logic       iWr,
   input  logic       iRd,
   input  logic [7:0] iData,
   output logic [7:0] oData,
   output logic       oOut
);

   localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

   logic [3:0]         presc_q, presc_d;
   logic [1:0]         mode_q, mode_d;
   logic [1:0]         acc_q, acc_d;
   pit_state_e         state_q, state_d;
   logic [COUNT_W-1:0] counter_q, counter_d;
   logic [COUNT_W-1:0] reload_q, reload_d;
   logic [COUNT_W-1:0] latch_q, latch_d;
   logic [7:0]         lsb_q, lsb_d;
   logic               wr_msb_q, wr_msb_d;
   logic               rd_msb_q, rd_msb_d;
   logic               latch_vld_q, latch_vld_d;
   logic               out_q, out_d;
   logic               gate_q;
`ifdef PIT_BCD_EN
   logic               bcd_q, bcd_d;
`endif

   logic               tick;
   logic               gate_rise;
   logic               m3_toggle;
   logic               rd_last;
   logic [COUNT_W-1:0] eff_reload;
   logic [COUNT_W-1:0] rd_src;
   logic [COUNT_W-1:0] dec_res;
   logic               dec_zero;

   pit_dec u_dec (
      .val_i  (counter_q),
      .by2_i  (mode_q == MODE_3),
`ifdef PIT_BCD_EN
      .bcd_i  (bcd_q),
`endif
      .res_o  (dec_res),
      .zero_o (dec_zero)
   );

   assign gate_rise  = iGate & ~gate_q;
   assign eff_reload = ((mode_q != MODE_0) && (reload_q == 16'd1)) ? 16'd2 : reload_q;
   // Mode 3: odd counts spend the extra tick in the high half.
   assign m3_toggle  = dec_zero | (out_q ? (counter_q == 16'd1) : (dec_res == 16'd1));

   assign rd_src  = latch_vld_q ? latch_q : counter_q;
   assign rd_last = (acc_q != ACC_WORD) || rd_msb_q;

   always_comb begin
      oData = rd_src[7:0];
      if (acc_q == ACC_MSB || (acc_q == ACC_WORD && rd_msb_q)) begin
         oData = rd_src[15:8];
      end
   end

   assign oOut = out_q;

   always_comb begin
      presc_d     = presc_q;
      tick        = 1'b0;
      state_d     = state_q;
      counter_d   = counter_q;
      out_d       = out_q;
      reload_d    = reload_q;
      lsb_d       = lsb_q;
      wr_msb_d    = wr_msb_q;
      rd_msb_d    = rd_msb_q;
      latch_d     = latch_q;
      latch_vld_d = latch_vld_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
`ifdef PIT_BCD_EN
      bcd_d       = bcd_q;
`endif

      if (iClkEn) begin
         tick    = (presc_q == DIV_LAST);
         presc_d = tick ? 4'd0 : presc_q + 4'd1;
      end

      if (mode_q != MODE_0 && !iGate) begin
         out_d = 1'b1;
      end

      case (state_q)
         LOAD: begin
            if (tick && (mode_q == MODE_0 || iGate)) begin
               counter_d = eff_reload;
               state_d   = COUNT;
               if (mode_q != MODE_0) out_d = 1'b1;
            end
         end
         COUNT: begin
            // A gate edge landing on a tick reloads right away, so only one reload happens.
            if (mode_q != MODE_0 && gate_rise) begin
               if (tick) begin
                  counter_d = eff_reload;
                  out_d     = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end else if (tick && iGate) begin
               case (mode_q)
                  MODE_0: begin
                     counter_d = dec_res;
                     if (dec_zero) out_d = 1'b1;
                  end
                  MODE_2: begin
                     if (counter_q == 16'd1) begin
                        counter_d = eff_reload;
                        out_d     = 1'b1;
                     end else begin
                        counter_d = dec_res;
                        if (dec_res == 16'd1) out_d = 1'b0;
                     end
                  end
                  default: begin
                     if (m3_toggle) begin
                        counter_d = eff_reload;
                        out_d     = ~out_q;
                     end else begin
                        counter_d = dec_res;
                     end
                  end
               endcase
            end
         end
         default: ;
      endcase

      if (iRd) begin
         if (acc_q == ACC_WORD) rd_msb_d = ~rd_msb_q;
         if (rd_last) latch_vld_d = 1'b0;
      end

      if (iCtrlWr) begin
         if (iData[5:4] == ACC_LATCH) begin
            if (!latch_vld_q) begin
               latch_d     = counter_q;
               latch_vld_d = 1'b1;
            end
         end else begin
            acc_d       = iData[5:4];
            mode_d      = map_mode(iData[3:1]);
`ifdef PIT_BCD_EN
            bcd_d       = iData[0];
`endif
            state_d     = IDLE;
            wr_msb_d    = 1'b0;
            rd_msb_d    = 1'b0;
            latch_vld_d = 1'b0;
            out_d       = (map_mode(iData[3:1]) != MODE_0);
         end
      end else if (iWr) begin
         case (acc_q)
            ACC_LSB: begin
               reload_d = {8'h00, iData};
               state_d  = LOAD;
            end
            ACC_MSB: begin
               reload_d = {iData, 8'h00};
               state_d  = LOAD;
            end
            default: begin
               if (!wr_msb_q) begin
                  lsb_d    = iData;
                  wr_msb_d = 1'b1;
                  if (mode_q == MODE_0) begin
                     state_d = IDLE;
                     out_d   = 1'b0;
                  end
               end else begin
                  reload_d = {iData, lsb_q};
                  wr_msb_d = 1'b0;
                  state_d  = LOAD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         presc_q     <= '0;
         mode_q      <= MODE_0;
         acc_q       <= ACC_WORD;
         state_q     <= IDLE;
         counter_q   <= '0;
         reload_q    <= '0;
         latch_q     <= '0;
         lsb_q       <= '0;
         wr_msb_q    <= 1'b0;
         rd_msb_q    <= 1'b0;
         latch_vld_q <= 1'b0;
         out_q       <= 1'b0;
         gate_q      <= 1'b0;
`ifdef PIT_BCD_EN
         bcd_q       <= 1'b0;
`endif
      end else begin
         presc_q     <= presc_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         state_q     <= state_d;
         counter_q   <= counter_d;
         reload_q    <= reload_d;
         latch_q     <= latch_d;
         lsb_q       <= lsb_d;
         wr_msb_q    <= wr_msb_d;
         rd_msb_q    <= rd_msb_d;
         latch_vld_q <= latch_vld_d;
         out_q       <= out_d;
         gate_q      <= iGate;
`ifdef PIT_BCD_EN
         bcd_q       <= bcd_d;
`endif
      end
   end

endmodule

// File: tb/tb_pit_channel.sv
// Directed self-checking bench for pit_channel (DIV=3, enable every cycle).
module tb_pit_channel;
   import pit_pkg::*;

   logic       iClk = 1'b0;
   logic       iRst;
   logic       iClkEn;
   logic       iGate;
   logic       iCtrlWr;
   logic       iWr;
   logic       iRd;
   logic [7:0] iData;
   logic [7:0] oData;
   logic       oOut;

   int         n_cmp = 0;
   int         n_err = 0;
   int         n;
   int         lows;
   logic [7:0] d;

   pit_channel #(.DIV(3)) dut (
      .iClk    (iClk),
      .iRst    (iRst),
      .iClkEn  (iClkEn),
      .iGate   (iGate),
      .iCtrlWr (iCtrlWr),
      .iWr     (iWr),
      .iRd     (iRd),
      .iData   (iData),
      .oData   (oData),
      .oOut    (oOut)
   );

   always #5 iClk = ~iClk;

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ctrl_wr(input logic [7:0] v);
      iCtrlWr = 1'b1;
      iData   = v;
      step();
      iCtrlWr = 1'b0;
   endtask

   task automatic cnt_wr(input logic [7:0] v);
      iWr   = 1'b1;
      iData = v;
      step();
      iWr   = 1'b0;
   endtask

   task automatic rd_byte(output logic [7:0] v);
      iRd = 1'b1;
      #1;
      v = oData;
      step();
      iRd = 1'b0;
   endtask

   // Steps until oOut equals lvl; gives up after 200 cycles (the count then fails its check).
   task automatic wait_out(input logic lvl, output int cnt);
      cnt = 0;
      while (oOut !== lvl && cnt < 200) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      iRst = 1'b1; iClkEn = 1'b1; iGate = 1'b1;
      iCtrlWr = 1'b0; iWr = 1'b0; iRd = 1'b0; iData = 8'h00;
      repeat (3) step();
      check("rst_out",   32'(oOut), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      check("rst_data",  32'(oData), 32'h00);
      iRst = 1'b0;
      step();

      // Mode 0, count 5: load tick plus five decrements, ticks every 3 clocks.
      ctrl_wr(8'h30);
      cnt_wr(8'h05);
      check("m0_out_first", 32'(oOut), 32'd0);
      cnt_wr(8'h00);
      check("m0_out_loaded", 32'(oOut), 32'd0);
      wait_out(1'b1, n);
      check("m0_rise_16to18", 32'(n >= 16 && n <= 18), 32'd1);
      lows = 0;
      repeat (30) begin
         step();
         if (oOut !== 1'b1) lows++;
      end
      check("m0_stays_high", 32'(lows), 32'd0);

      // Mode 2, count 4: one tick low (3 clocks) in every 4 ticks (12 clocks).
      ctrl_wr(8'h34);
      check("m2_ctrl_out", 32'(oOut), 32'd1);
      cnt_wr(8'h04);
      cnt_wr(8'h00);
      wait_out(1'b0, n);
      for (int p = 0; p < 5; p++) begin
         wait_out(1'b1, n);
         check("m2_low", 32'(n), 32'd3);
         wait_out(1'b0, n);
         check("m2_high", 32'(n), 32'd9);
      end

      // Gate low forces high; after the rise the reload tick lands 1..3 clocks later
      // and the output falls three ticks after that.
      iGate = 1'b0;
      step();
      check("m2_gate_force", 32'(oOut), 32'd1);
      lows = 0;
      repeat (30) begin
         step();
         if (oOut !== 1'b1) lows++;
      end
      check("m2_gate_held", 32'(lows), 32'd0);
      iGate = 1'b1;
      wait_out(1'b0, n);
      check("m2_gate_fall_10to12", 32'(n >= 10 && n <= 12), 32'd1);
      wait_out(1'b1, n);
      check("m2_gate_low", 32'(n), 32'd3);

      // Mode 3, count 5: high 3 ticks, low 2 ticks.
      ctrl_wr(8'h36);
      cnt_wr(8'h05);
      cnt_wr(8'h00);
      wait_out(1'b0, n);
      for (int p = 0; p < 2; p++) begin
         wait_out(1'b1, n);
         check("m3_n5_low", 32'(n), 32'd6);
         wait_out(1'b0, n);
         check("m3_n5_high", 32'(n), 32'd9);
      end

      // Mode 3, count 4: 2 ticks each way.
      ctrl_wr(8'h36);
      cnt_wr(8'h04);
      cnt_wr(8'h00);
      wait_out(1'b0, n);
      for (int p = 0; p < 2; p++) begin
         wait_out(1'b1, n);
         check("m3_n4_low", 32'(n), 32'd6);
         wait_out(1'b0, n);
         check("m3_n4_high", 32'(n), 32'd6);
      end

      // Mode 0 with the gate low holds the counter at 0x1234 after loading.
      iGate = 1'b0;
      ctrl_wr(8'h30);
      cnt_wr(8'h34);
      cnt_wr(8'h12);
      repeat (6) step();
      rd_byte(d);
      check("live_lsb_frozen", 32'(d), 32'h34);
      rd_byte(d);
      check("live_msb_frozen", 32'(d), 32'h12);

      // Latch while counting resumes; the latch holds 0x1234 while 4 or 5 ticks pass.
      iGate = 1'b1;
      ctrl_wr(8'h00);
      repeat (10) step();
      rd_byte(d);
      check("latch_lsb", 32'(d), 32'h34);
      rd_byte(d);
      check("latch_msb", 32'(d), 32'h12);
      rd_byte(d);
      check("live_lsb_moving", 32'(d == 8'h30 || d == 8'h2F), 32'd1);
      rd_byte(d);
      check("live_msb_moving", 32'(d), 32'h12);

      // Mode 3 running, reset asserted while output is high.
      ctrl_wr(8'h36);
      cnt_wr(8'h04);
      cnt_wr(8'h00);
      repeat (20) step();
      wait_out(1'b1, n);
      check("pre_rst_out", 32'(oOut), 32'd1);
      iRst = 1'b1;
      #1;
      check("midrst_out",   32'(oOut), 32'd0);
      check("midrst_state", 32'(dut.state_q), 32'(IDLE));
      check("midrst_data",  32'(oData), 32'h00);
      step();
      iRst = 1'b0;
      repeat (30) step();
      check("postrst_state", 32'(dut.state_q), 32'(IDLE));
      check("postrst_out",   32'(oOut), 32'd0);
      check("postrst_data",  32'(oData), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
